gomoku_move_scan: RTL and testbench
===================================

GOMOKU_MOVE_SCAN -- requirements
Module: gomoku_move_scan

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: scan request, sampled in IDLE only.
REQ-004 SHALL have port abort, input, 1 bit: synchronous scan cancel.
REQ-005 SHALL have port ai_color, input, 1 bit: own side, 0=black, 1=white; sampled with start.
REQ-006 SHALL have ports consider_y, consider_x, output, 4 bits each: cell coordinate driven to the board datapath.
REQ-007 SHALL have ports black_y, black_x, black_yx, black_xy, white_y, white_x, white_yx, white_xy, input, 9 bits each: line windows around the consider cell. Bit 4 is the centre. Bits 3..0 are the run walking away on one side. Bits 5..8 are the run walking away on the other side. Off-board bits read 0.
REQ-008 SHALL have port busy, output, 1 bit: high in SCAN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-010 SHALL have port valid, output, 1 bit: at least one empty cell was found.
REQ-011 SHALL have ports best_y, best_x, output, 4 bits each, and best_score, output, 16 bits: result of the last completed scan.

Function
REQ-012 SHALL have FSM states IDLE, SCAN, DONE.
- IDLE->SCAN on start.
- SCAN->DONE after cell (14,14).
- DONE->IDLE unconditionally.
REQ-013 SHALL visit cells in row-major order, (0,0)..(14,14), one cell per SCAN cycle. The windows are consumed combinationally in the same cycle; the board updates on negedge.
REQ-014 SHALL drive consider_y/x = 0/0 in IDLE and DONE.
REQ-015 SHALL treat a cell as occupied when black_y[4] | white_y[4] = 1. Occupied cells SHALL be skipped and never compared.
REQ-016 SHALL compute run L(dir, colour) for each of the 4 directions and each colour:
- count consecutive set bits from bit 3 downward, plus consecutive set bits from bit 5 upward;
- saturate at 4.
REQ-017 SHALL use these weights:
- own colour: L=1:10, 2:100, 3:1000, 4:10000;
- opponent colour: L=1:5, 2:50, 3:500, 4:5000;
- L=0: 0.
REQ-018 SHALL set score = sum of the 8 weights, unsigned 16 bits. The maximum is 60000 and no overflow is possible.
REQ-019 SHALL take the first empty cell of a scan unconditionally. Each later empty cell SHALL replace the current best only if its score is strictly greater, so ties keep the earliest cell in scan order.
REQ-020 SHALL commit best_y/x/score and valid at the DONE cycle, with done=1 for exactly that cycle. done therefore rises 226 cycles after the start edge.
REQ-021 SHALL, when no empty cell exists: valid=0, best_y/x=7/7, best_score=0, done still pulses.
REQ-022 SHALL ignore start in SCAN and DONE.
REQ-023 SHALL respond to abort in SCAN by entering IDLE next cycle. There SHALL be no done pulse, and the outputs SHALL keep their previous values. abort in IDLE or DONE SHALL be ignored. abort and start together in IDLE: abort wins.
REQ-024 SHALL not detect board writes during SCAN; the controller holds the board static while busy=1.

Reset
REQ-025 SHALL, on rst low at any time including mid-scan, immediately enter IDLE with:
- consider_y/x=0, busy=0, done=0, valid=0;
- best_y/x=7/7, best_score=0;
- internal best and found registers cleared.
REQ-026 SHALL, after rst deasserts, require a fresh start; no scan resumes.

Configuration
REQ-027 SHALL support macro GOMOKU_CENTER_BIAS_EN.
- When defined: add bias = 14 - (|y-7| + |x-7|), range 0..14, to each empty cell's score before comparison; maximum 60014.
- When undefined: no bias, and scoring is exactly per REQ-018.

Verification
REQ-028 Empty board, start, ai_color=1 -> done at cycle 226, valid=1. Without the macro: best (0,0), score 0. With the macro: best (7,7), score 14.
REQ-029 Black at (7,3..6), ai_color=1. Without the macro: best (7,2), score 5000, chosen over (7,7) by tie order. With the macro: best (7,7), score 5014.
REQ-030 White at (0..3,0), ai_color=1, no macro -> best (4,0), score 10000.
REQ-031 All 225 cells occupied -> valid=0, best (7,7), score 0, one done pulse.
REQ-032 abort in SCAN cycle 100 -> busy low next cycle, no done, outputs unchanged from the previous scan. A second start mid-scan is ignored.
REQ-033 rst low at SCAN cycle 50 -> all outputs at their REQ-025 values asynchronously. Then start -> a normal scan completes.

Source files
------------

// File: rtl/gomoku_move_scan.sv
// Gomoku move scanner: walks the 15x15 board in row-major order, scores every empty cell
// from its line windows and keeps the best. Optional macro GOMOKU_CENTER_BIAS_EN favours the centre.
module gomoku_move_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        ai_color,
  output logic [3:0]  consider_y,
  output logic [3:0]  consider_x,
  input  logic [8:0]  black_y,
  input  logic [8:0]  black_x,
  input  logic [8:0]  black_yx,
  input  logic [8:0]  black_xy,
  input  logic [8:0]  white_y,
  input  logic [8:0]  white_x,
  input  logic [8:0]  white_yx,
  input  logic [8:0]  white_xy,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [3:0]  best_y,
  output logic [3:0]  best_x,
  output logic [15:0] best_score
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cur_y, cur_x;
  logic        color_q;
  logic        found_q, found_nx;
  logic [3:0]  cand_y, cand_x, cand_y_nx, cand_x_nx;
  logic [15:0] cand_score, cand_score_nx;
  logic [15:0] cell_score, bias, total_score;
  logic        occupied, take, last_cell;
  logic [8:0]  blk_w [4];
  logic [8:0]  wht_w [4];

  // Run through the centre: adjacent set bits on each side, capped at a five-in-a-row threat.
  function automatic logic [2:0] run_len(input logic [8:0] w);
    logic [3:0] n;
    logic       lo_go, hi_go;
    n     = '0;
    lo_go = 1'b1;
    hi_go = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      lo_go = lo_go & w[4-k];
      hi_go = hi_go & w[4+k];
      n     = n + {3'b000, lo_go} + {3'b000, hi_go};
    end
    return (n > 4'd4) ? 3'd4 : n[2:0];
  endfunction

  function automatic logic [15:0] weight(input logic [2:0] len, input logic own);
    logic [15:0] w;
    case (len)
      3'd1:    w = own ? 16'd10    : 16'd5;
      3'd2:    w = own ? 16'd100   : 16'd50;
      3'd3:    w = own ? 16'd1000  : 16'd500;
      3'd4:    w = own ? 16'd10000 : 16'd5000;
      default: w = 16'd0;
    endcase
    return w;
  endfunction

  assign blk_w = '{black_y, black_x, black_yx, black_xy};
  assign wht_w = '{white_y, white_x, white_yx, white_xy};

  // NOTE: blocking assignments are correct here: the sum is combinational and each
  // loop iteration must see the previous partial result.
  always_comb begin
    cell_score = '0;
    for (int i = 0; i < 4; i++) begin
      cell_score = cell_score
                 + weight(run_len(color_q ? wht_w[i] : blk_w[i]), 1'b1)
                 + weight(run_len(color_q ? blk_w[i] : wht_w[i]), 1'b0);
    end
  end

`ifdef GOMOKU_CENTER_BIAS_EN
  logic [3:0] dist_y, dist_x;
  logic [4:0] dist;
  always_comb begin
    dist_y = (cur_y >= 4'd7) ? cur_y - 4'd7 : 4'd7 - cur_y;
    dist_x = (cur_x >= 4'd7) ? cur_x - 4'd7 : 4'd7 - cur_x;
    dist   = {1'b0, dist_y} + {1'b0, dist_x};
    bias   = 16'd14 - {11'd0, dist};
  end
`else
  assign bias = '0;
`endif

  assign total_score = cell_score + bias;
  assign occupied    = black_y[4] | white_y[4];
  // The first empty cell wins unconditionally; strict '>' keeps the earliest cell on ties.
  assign take        = !occupied && (!found_q || (total_score > cand_score));
  assign last_cell   = (cur_y == 4'd14) && (cur_x == 4'd14);

  assign found_nx      = found_q | take;
  assign cand_y_nx     = take ? cur_y       : cand_y;
  assign cand_x_nx     = take ? cur_x       : cand_x;
  assign cand_score_nx = take ? total_score : cand_score;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    consider_y = '0;
    consider_x = '0;
    case (state)
      IDLE: if (start && !abort) state_nx = SCAN;
      SCAN: begin
        busy       = 1'b1;
        consider_y = cur_y;
        consider_x = cur_x;
        if (abort)          state_nx = IDLE;
        else if (last_cell) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_y      <= '0;
      cur_x      <= '0;
      color_q    <= 1'b0;
      found_q    <= 1'b0;
      cand_y     <= '0;
      cand_x     <= '0;
      cand_score <= '0;
      valid      <= 1'b0;
      best_y     <= 4'd7;
      best_x     <= 4'd7;
      best_score <= '0;
    end else if (state == IDLE && start && !abort) begin
      cur_y   <= '0;
      cur_x   <= '0;
      found_q <= 1'b0;
      color_q <= ai_color;
    end else if (state == SCAN && !abort) begin
      found_q    <= found_nx;
      cand_y     <= cand_y_nx;
      cand_x     <= cand_x_nx;
      cand_score <= cand_score_nx;
      if (cur_x == 4'd14) begin
        cur_x <= '0;
        cur_y <= cur_y + 4'd1;
      end else begin
        cur_x <= cur_x + 4'd1;
      end
      if (last_cell) begin
        valid      <= found_nx;
        best_y     <= found_nx ? cand_y_nx     : 4'd7;
        best_x     <= found_nx ? cand_x_nx     : 4'd7;
        best_score <= found_nx ? cand_score_nx : 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_gomoku_move_scan.sv
// Directed bench for gomoku_move_scan: a board model feeds line windows on negedge and
// each scenario is checked against hand-computed results (both GOMOKU_CENTER_BIAS_EN builds).
module tb_gomoku_move_scan;

  logic        clk = 1'b0;
  logic        rst, start, abort, ai_color;
  logic [3:0]  consider_y, consider_x;
  logic [8:0]  black_y, black_x, black_yx, black_xy;
  logic [8:0]  white_y, white_x, white_yx, white_xy;
  logic        busy, done, valid;
  logic [3:0]  best_y, best_x;
  logic [15:0] best_score;

  logic [14:0] blk [15];
  logic [14:0] wht [15];
  int          n_checks = 0;
  int          n_fail = 0;
  int          edges;
  int          done_cnt;

`ifdef GOMOKU_CENTER_BIAS_EN
  localparam int E28_Y = 7, E28_X = 7, E28_S = 14;
  localparam int E29_Y = 7, E29_X = 7, E29_S = 5014;
  localparam int E30_S = 10004, E30B_S = 5004;
  localparam int E1S_Y = 7, E1S_X = 7, E1S_S = 14;
  localparam int ESAT_S = 10012;
`else
  localparam int E28_Y = 0, E28_X = 0, E28_S = 0;
  localparam int E29_Y = 7, E29_X = 2, E29_S = 5000;
  localparam int E30_S = 10000, E30B_S = 5000;
  localparam int E1S_Y = 0, E1S_X = 1, E1S_S = 5;
  localparam int ESAT_S = 10000;
`endif

  always #5 clk = ~clk;

  gomoku_move_scan dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ai_color(ai_color),
    .consider_y(consider_y), .consider_x(consider_x),
    .black_y(black_y), .black_x(black_x), .black_yx(black_yx), .black_xy(black_xy),
    .white_y(white_y), .white_x(white_x), .white_yx(white_yx), .white_xy(white_xy),
    .busy(busy), .done(done), .valid(valid),
    .best_y(best_y), .best_x(best_x), .best_score(best_score)
  );

  function automatic logic cell_at(input bit white, input int y, input int x);
    if (y < 0 || y > 14 || x < 0 || x > 14) return 1'b0;
    return white ? wht[y][x] : blk[y][x];
  endfunction

  function automatic logic [8:0] win(input bit white, input int y, input int x,
                                     input int dy, input int dx);
    logic [8:0] w;
    for (int k = -4; k <= 4; k++) w[4+k] = cell_at(white, y + k*dy, x + k*dx);
    return w;
  endfunction

  // Board datapath model: windows follow consider_y/x on the falling edge.
  always @(negedge clk) begin
    black_y  = win(1'b0, int'(consider_y), int'(consider_x), 1, 0);
    black_x  = win(1'b0, int'(consider_y), int'(consider_x), 0, 1);
    black_yx = win(1'b0, int'(consider_y), int'(consider_x), 1, 1);
    black_xy = win(1'b0, int'(consider_y), int'(consider_x), 1, -1);
    white_y  = win(1'b1, int'(consider_y), int'(consider_x), 1, 0);
    white_x  = win(1'b1, int'(consider_y), int'(consider_x), 0, 1);
    white_yx = win(1'b1, int'(consider_y), int'(consider_x), 1, 1);
    white_xy = win(1'b1, int'(consider_y), int'(consider_x), 1, -1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 15; y++) begin
      blk[y] = '0;
      wht[y] = '0;
    end
  endtask

  // Start a scan and count rising edges from the start edge (inclusive) until done.
  task automatic launch(input logic ai);
    @(negedge clk);
    start = 1'b1;
    ai_color = ai;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_scan(input string tag, input logic ai, input int exp_valid,
                         input int exp_y, input int exp_x, input int exp_score);
    launch(ai);
    while (!done && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, edges, 226);
    check({tag, "_valid"}, valid, exp_valid);
    check({tag, "_best_y"}, best_y, exp_y);
    check({tag, "_best_x"}, best_x, exp_x);
    check({tag, "_score"}, best_score, exp_score);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_cons_done"}, {consider_y, consider_x}, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; ai_color = 1'b0;
    clear_board();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_best", {best_y, best_x}, {4'd7, 4'd7});
    check("rst_score", best_score, 0);
    check("rst_consider", {consider_y, consider_x}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_scan("empty", 1'b1, 1, E28_Y, E28_X, E28_S);

    clear_board();
    for (int x = 3; x <= 6; x++) blk[7][x] = 1'b1;
    do_scan("four_opp_row", 1'b1, 1, E29_Y, E29_X, E29_S);

    clear_board();
    for (int y = 0; y <= 3; y++) wht[y][0] = 1'b1;
    do_scan("four_own_col", 1'b1, 1, 4, 0, E30_S);
    do_scan("four_opp_col", 1'b0, 1, 4, 0, E30B_S);

    clear_board();
    blk[0][0] = 1'b1;
    do_scan("single_stone", 1'b1, 1, E1S_Y, E1S_X, E1S_S);

    // (0,0): own run 3 across, opponent run 2 down, own run 1 diagonal -> 1060.
    clear_board();
    blk[0][1] = 1'b1; blk[0][2] = 1'b1; blk[0][3] = 1'b1; blk[1][1] = 1'b1;
    wht[1][0] = 1'b1; wht[2][0] = 1'b1;
    do_scan("mixed", 1'b0, 1, 0, 0, 1060);

    clear_board();
    for (int y = 0; y < 15; y++) blk[y] = '1;
    do_scan("full", 1'b1, 0, 7, 7, 0);

    // Two runs of three meet at (7,5): 6 stones saturate to L=4.
    clear_board();
    for (int x = 2; x <= 8; x++) if (x != 5) blk[7][x] = 1'b1;
    do_scan("saturate", 1'b0, 1, 7, 5, ESAT_S);

    // Abort mid-scan, with a second start in between that must be ignored.
    launch(1'b0);
    while (edges < 50) begin @(posedge clk); edges++; @(negedge clk); end
    start = 1'b1;
    @(posedge clk); edges++; @(negedge clk);
    start = 1'b0;
    check("restart_ign_y", consider_y, 3);
    check("restart_ign_x", consider_x, 5);
    while (edges < 100) begin @(posedge clk); edges++; @(negedge clk); end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    done_cnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_valid", valid, 1);
    check("abort_best", {best_y, best_x}, {4'd7, 4'd5});
    check("abort_score", best_score, ESAT_S);

    // abort beats start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_wins", busy, 0);
    @(negedge clk);
    check("idle_abort_quiet", busy, 0);

    // Asynchronous reset in the middle of a scan.
    clear_board();
    launch(1'b1);
    while (edges < 50) begin @(posedge clk); edges++; @(negedge clk); end
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_best", {best_y, best_x}, {4'd7, 4'd7});
    check("mid_rst_score", best_score, 0);
    check("mid_rst_consider", {consider_y, consider_x}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("no_resume", busy, 0);
    do_scan("post_rst", 1'b1, 1, E28_Y, E28_X, E28_S);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
